// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: funct3 encodings for loads/stores, the
// data-memory port FSM states and a helper that decodes access width.
package rv32i_types;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_size_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Loads and stores decode funct3 differently; any undefined encoding
    // falls through to a full-word access.
    function automatic acc_size_t access_size(input logic is_store, input logic [2:0] funct3);
        acc_size_t size;
        size = ACC_WORD;
        if (is_store) begin
            case (funct3)
                F3_SB:   size = ACC_BYTE;
                F3_SH:   size = ACC_HALF;
                default: size = ACC_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = ACC_BYTE;
                F3_LH, F3_LHU: size = ACC_HALF;
                default:       size = ACC_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/dmem_access_unit_align.sv
// Purely combinational lane alignment for the data port: byte-enable mask,
// lane-shifted store data, extended load data and the misalignment flag.
module dmem_align
    import rv32i_types::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [DATA_W-1:0]     data_rdata,
    output logic [DATA_W/8-1:0]   mask,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     load_data,
    output logic                  misalign
);

    acc_size_t         size;
    logic [DATA_W-1:0] shifted;

    assign size    = access_size(is_store, funct3);
    assign shifted = data_rdata >> {addr_lo, 3'b000};

    // Mask, store lanes and alignment check all follow from the access width.
    always_comb begin
        mask     = '0;
        wdata    = '0;
        misalign = 1'b0;
        case (size)
            ACC_BYTE: begin
                mask     = MASK_BYTE << addr_lo;
                wdata    = {{(DATA_W-8){1'b0}}, store_data[7:0]} << {addr_lo, 3'b000};
                misalign = 1'b0;
            end
            ACC_HALF: begin
                mask     = MASK_HALF << addr_lo;
                wdata    = {{(DATA_W-16){1'b0}}, store_data[15:0]} << {addr_lo[1], 4'b0000};
                misalign = addr_lo[0];
            end
            default: begin
                mask     = MASK_WORD << addr_lo;
                wdata    = store_data;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

    // Load extension: the addressed byte/half is already at bit 0 of shifted.
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_LH:   load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-port controller: issues one registered cache request per
// aligned load/store, stalls the pipeline until the cache responds, and
// returns the extended load result for one cycle.
module dmem_access_unit
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     store_data,
    output logic                  data_read,
    output logic                  data_write,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W/8-1:0]   data_mbe,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W-1:0]     data_rdata,
    input  logic                  data_resp,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
    output logic                  load_valid,
    output logic                  misaligned
);

    dmem_state_t         state_q, state_d;
    logic                data_read_q, data_read_d;
    logic                data_write_q, data_write_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [DATA_W/8-1:0] data_mbe_q, data_mbe_d;
    logic [DATA_W-1:0]   data_wdata_q, data_wdata_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                load_valid_q, load_valid_d;

    logic                is_req;
    logic                stall_c;
    logic                misaligned_c;
    logic [DATA_W/8-1:0] align_mask;
    logic [DATA_W-1:0]   align_wdata;
    logic [DATA_W-1:0]   align_load;
    logic                align_misalign;

    // A write request wins when both read and write are flagged.
    assign is_req = req_valid & (mem_read | mem_write);

    dmem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .is_store   (mem_write),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .data_rdata (data_rdata),
        .mask       (align_mask),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misalign   (align_misalign)
    );

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            data_read_q  <= 1'b0;
            data_write_q <= 1'b0;
            data_addr_q  <= '0;
            data_mbe_q   <= '0;
            data_wdata_q <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_read_q  <= data_read_d;
            data_write_q <= data_write_d;
            data_addr_q  <= data_addr_d;
            data_mbe_q   <= data_mbe_d;
            data_wdata_q <= data_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
        end
    end

    // Next-state and combinational stall/misaligned for the request FSM.
    always_comb begin
        state_d      = state_q;
        data_read_d  = data_read_q;
        data_write_d = data_write_q;
        data_addr_d  = data_addr_q;
        data_mbe_d   = data_mbe_q;
        data_wdata_d = data_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = load_valid_q;
        stall_c      = 1'b0;
        misaligned_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_req) begin
                    if (align_misalign) begin
                        // Dropped access: no request, pipeline not held.
                        misaligned_c = 1'b1;
                    end else begin
                        stall_c      = 1'b1;
                        data_read_d  = ~mem_write;
                        data_write_d = mem_write;
                        data_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        data_mbe_d   = align_mask;
                        data_wdata_d = mem_write ? align_wdata : '0;
                        state_d      = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (data_resp) begin
                    data_read_d  = 1'b0;
                    data_write_d = 1'b0;
                    // The registered read flag tells us this was a load.
                    if (data_read_q) begin
                        load_data_d  = align_load;
                        load_valid_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // One unstalled cycle lets the pipeline move past the op.
                load_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // While reset is held the FSM is forced to IDLE, so gate the
    // request-driven combinational outputs as well.
    assign stall      = rst ? stall_c : 1'b0;
    assign misaligned = rst ? misaligned_c : 1'b0;

    assign data_read  = data_read_q;
    assign data_write = data_write_q;
    assign data_addr  = data_addr_q;
    assign data_mbe   = data_mbe_q;
    assign data_wdata = data_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: byte-level reference model plus directed
// load/store/misalign/reset scenarios with literal expectations.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [3:0]  data_mbe;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata = 32'h0;
    logic        data_resp = 1'b0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_mbe   (data_mbe),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_resp  (data_resp),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-level) ----------------
    function automatic int nbytes(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input logic is_store, input logic [2:0] f3, input logic [1:0] lo);
        return (int'(lo) % nbytes(is_store, f3)) != 0;
    endfunction

    function automatic logic [3:0] m_mbe(input logic is_store, input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m = 4'b0;
        for (int i = 0; i < nbytes(is_store, f3); i++)
            if (int'(lo) + i < 4) m[int'(lo) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] sd);
        logic [31:0] w = 32'h0;
        logic [3:0]  m = m_mbe(1'b1, f3, lo);
        for (int k = 0; k < 4; k++)
            if (m[k]) w[8*k +: 8] = sd[8*(k - int'(lo)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] v = 32'h0;
        int nb = nbytes(1'b0, f3);
        for (int i = 0; i < nb; i++)
            if (int'(lo) + i < 4) v[8*i +: 8] = rd[8*(int'(lo) + i) +: 8];
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    bit          m_busy, m_done, m_load_op;
    logic        e_read, e_write, e_lv;
    logic [31:0] e_addr, e_wdata, e_ld;
    logic [3:0]  e_mbe;
    logic        m_req;
    assign m_req = req_valid & (mem_read | mem_write);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_done <= 0; m_load_op <= 0;
            e_read <= 0; e_write <= 0; e_lv <= 0;
            e_addr <= 0; e_wdata <= 0; e_ld <= 0; e_mbe <= 0;
        end else if (m_busy) begin
            if (data_resp) begin
                m_busy <= 0; m_done <= 1; e_read <= 0; e_write <= 0;
                if (m_load_op) begin
                    e_ld <= m_load(funct3, addr[1:0], data_rdata);
                    e_lv <= 1;
                end
            end
        end else if (m_done) begin
            m_done <= 0; e_lv <= 0;
        end else if (m_req && !m_mis(mem_write, funct3, addr[1:0])) begin
            m_busy    <= 1;
            m_load_op <= !mem_write;
            e_read    <= !mem_write;
            e_write   <= mem_write;
            e_addr    <= addr & 32'hFFFF_FFFC;
            e_mbe     <= m_mbe(mem_write, funct3, addr[1:0]);
            e_wdata   <= mem_write ? m_wdata(funct3, addr[1:0], store_data) : 32'h0;
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        logic idle_req;
        idle_req = rst && !m_busy && !m_done && m_req;
        if (!rst) begin
            chk("rst_read", {31'b0, data_read}, 32'h0);
            chk("rst_write", {31'b0, data_write}, 32'h0);
            chk("rst_lv", {31'b0, load_valid}, 32'h0);
            chk("rst_stall", {31'b0, stall}, 32'h0);
            chk("rst_mis", {31'b0, misaligned}, 32'h0);
            chk("rst_addr", data_addr, 32'h0);
            chk("rst_ld", load_data, 32'h0);
        end else begin
            chk("m_stall", {31'b0, stall},
                {31'b0, m_busy || (idle_req && !m_mis(mem_write, funct3, addr[1:0]))});
            chk("m_mis", {31'b0, misaligned},
                {31'b0, idle_req && m_mis(mem_write, funct3, addr[1:0])});
            chk("m_never_both", {31'b0, stall & misaligned}, 32'h0);
            chk("m_read", {31'b0, data_read}, {31'b0, e_read});
            chk("m_write", {31'b0, data_write}, {31'b0, e_write});
            chk("m_lv", {31'b0, load_valid}, {31'b0, e_lv});
            if (e_read || e_write) begin
                chk("m_addr", data_addr, e_addr);
                chk("m_mbe", {28'b0, data_mbe}, {28'b0, e_mbe});
            end
            if (e_write) chk("m_wdata", data_wdata, e_wdata);
            if (e_lv) chk("m_ld", load_data, e_ld);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] o_ld, o_wdata, o_addr;
    logic [3:0]  o_mbe;
    int          o_busy, o_stall;
    bit          o_lv, o_rd, o_wr;

    // One memory op: request in cycle 0, response in cycle 1+dly, DONE in 2+dly.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdv, input int dly);
        o_busy = 0; o_stall = 0; o_lv = 0; o_rd = 0; o_wr = 0;
        o_ld = 32'h0; o_wdata = 32'h0; o_addr = 32'h0; o_mbe = 4'h0;
        @(posedge clk); #1;
        req_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; data_resp = 0; data_rdata = 32'h0;
        for (int k = 0; k <= dly + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                data_resp  = (k == dly + 1);
                data_rdata = (k == dly + 1) ? rdv : 32'h0;
                if (k == dly + 2) req_valid = 0;
            end
            @(negedge clk);
            if (stall) o_stall++;
            if (data_read || data_write) begin
                o_busy++;
                o_rd = o_rd | data_read;
                o_wr = o_wr | data_write;
                o_mbe = data_mbe; o_wdata = data_wdata; o_addr = data_addr;
            end
            if (k == dly + 2) begin
                o_ld = load_data; o_lv = load_valid;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("reset_read", {31'b0, data_read}, 32'h0);
        chk("reset_mbe", {28'b0, data_mbe}, 32'h0);
        chk("reset_wdata", data_wdata, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);

        // lw, addr 0x100, immediate response
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        $display("lw  0x100 -> ld=%h lv=%0d mbe=%b stall_cycles=%0d", o_ld, o_lv, o_mbe, o_stall);
        chk("lw_ld", o_ld, 32'hDEADBEEF);
        chk("lw_lv", {31'b0, o_lv}, 32'h1);
        chk("lw_mbe", {28'b0, o_mbe}, 32'hF);
        chk("lw_addr", o_addr, 32'h100);
        chk("lw_stall_cycles", o_stall, 2);
        chk("lw_busy_cycles", o_busy, 1);

        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
        $display("lb  0x103 -> ld=%h mbe=%b", o_ld, o_mbe);
        chk("lb_mbe", {28'b0, o_mbe}, 32'h8);
        chk("lb_ld", o_ld, 32'hFFFFFF80);

        run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0);
        $display("lbu 0x103 -> ld=%h", o_ld);
        chk("lbu_ld", o_ld, 32'h00000080);

        run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1);
        $display("lh  0x102 -> ld=%h mbe=%b", o_ld, o_mbe);
        chk("lh_ld", o_ld, 32'hFFFF8001);
        chk("lh_mbe", {28'b0, o_mbe}, 32'hC);

        run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h12345678, 0);
        $display("lhu 0x102 -> ld=%h", o_ld);
        chk("lhu_ld", o_ld, 32'h00001234);

        run_op(0, 1, 3'b000, 32'h101, 32'h11223344, 32'h0, 0);
        $display("sb  0x101 -> mbe=%b wdata=%h lv=%0d", o_mbe, o_wdata, o_lv);
        chk("sb_mbe", {28'b0, o_mbe}, 32'h2);
        chk("sb_wdata", o_wdata, 32'h00004400);
        chk("sb_no_lv", {31'b0, o_lv}, 32'h0);

        run_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3);
        $display("sh  0x202 -> mbe=%b wdata=%h write_cycles=%0d", o_mbe, o_wdata, o_busy);
        chk("sh_mbe", {28'b0, o_mbe}, 32'hC);
        chk("sh_wdata", o_wdata, 32'hABCD0000);
        chk("sh_write_cycles", o_busy, 4);
        chk("sh_addr", o_addr, 32'h200);

        run_op(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0);
        $display("rd+wr sw 0x300 -> rd=%0d wr=%0d wdata=%h", o_rd, o_wr, o_wdata);
        chk("both_is_store_wr", {31'b0, o_wr}, 32'h1);
        chk("both_is_store_rd", {31'b0, o_rd}, 32'h0);
        chk("both_wdata", o_wdata, 32'hCAFEF00D);

        run_op(1, 0, 3'b011, 32'h500, 32'h0, 32'hA5A5F00F, 0);
        $display("undef f3=011 load -> mbe=%b ld=%h", o_mbe, o_ld);
        chk("undef_mbe", {28'b0, o_mbe}, 32'hF);
        chk("undef_ld", o_ld, 32'hA5A5F00F);

        // misaligned sw
        @(posedge clk); #1;
        req_valid = 1; mem_read = 0; mem_write = 1; funct3 = 3'b010; addr = 32'h101;
        @(negedge clk);
        $display("sw  0x101 -> misaligned=%0d stall=%0d", misaligned, stall);
        chk("sw_mis", {31'b0, misaligned}, 32'h1);
        chk("sw_mis_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("sw_mis_nowrite", {31'b0, data_write}, 32'h0);
        chk("sw_mis_pulse", {31'b0, misaligned}, 32'h0);

        // misaligned lh
        @(posedge clk); #1;
        req_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b001; addr = 32'h103;
        @(negedge clk);
        $display("lh  0x103 -> misaligned=%0d", misaligned);
        chk("lh_mis", {31'b0, misaligned}, 32'h1);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("lh_mis_noread", {31'b0, data_read}, 32'h0);

        // reset in BUSY
        @(posedge clk); #1;
        req_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_read", {31'b0, data_read}, 32'h1);
        #2 rst = 0;
        #1;
        $display("reset in BUSY -> read=%0d stall=%0d", data_read, stall);
        chk("abort_read", {31'b0, data_read}, 32'h0);
        chk("abort_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk); rst = 1;

        run_op(1, 0, 3'b010, 32'h404, 32'h0, 32'h13579BDF, 1);
        $display("lw  0x404 after reset -> ld=%h lv=%0d", o_ld, o_lv);
        chk("post_rst_ld", o_ld, 32'h13579BDF);
        chk("post_rst_lv", {31'b0, o_lv}, 32'h1);

        // stray response in IDLE and a request with req_valid=0
        @(posedge clk); #1;
        req_valid = 0; mem_read = 1; mem_write = 1; funct3 = 3'b010; addr = 32'h800;
        data_resp = 1; data_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1 data_resp = 0;
        @(negedge clk);
        $display("stray resp -> read=%0d write=%0d lv=%0d ld=%h", data_read, data_write, load_valid, load_data);
        chk("stray_read", {31'b0, data_read}, 32'h0);
        chk("stray_write", {31'b0, data_write}, 32'h0);
        chk("stray_lv", {31'b0, load_valid}, 32'h0);
        chk("stray_ld_hold", load_data, 32'h13579BDF);
        chk("stray_stall", {31'b0, stall}, 32'h0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
